// File: rtl/conv_sched.sv
// Tile scheduler: sweeps all crossbar columns per input slice, accumulates ADC results per column, then streams the sums.
// Slice-to-ready latency DEPTH+LAT+1 cycles; in_ready low while sweeping, out_valid holds data/addr stable under out_ready=0.
module conv_sched #(
    parameter int INPUT_SIZE = 128,
    parameter int DEPTH      = 32,
    parameter int ADC_P      = 8,
    parameter int TILES      = 4,
    parameter int LAT        = 1,
    parameter int ACC_W      = 10,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] in_feature,
    output logic                  pim_en,
    output logic [INPUT_SIZE-1:0] pim_feature,
    output logic [AW-1:0]         pim_addr,
    input  logic [ADC_P-1:0]      pim_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic [AW-1:0]         out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int SW = ((ACC_W > ADC_P) ? ACC_W : ADC_P) + 1;

    localparam logic [AW-1:0] LAST_COL   = AW'(DEPTH - 1);
    localparam logic [TW-1:0] LAST_TILE  = TW'(TILES - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(LAT - 1);
    localparam logic [SW-1:0] ACC_MAX    = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SWEEP     = 3'd1,
        DRAIN     = 3'd2,
        WAIT_TILE = 3'd3,
        EMIT      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           col_q;
    logic [AW-1:0]           emit_q;
    logic [TW-1:0]           tile_q;
    logic [DW-1:0]           drain_q;
    logic [INPUT_SIZE-1:0]   feat_q;
    logic                    done_q;

    logic                    pv_q [LAT];
    logic [AW-1:0]           pa_q [LAT];
    logic [ACC_W-1:0]        acc  [DEPTH];

    logic                    accept;
    logic                    issue;
    logic                    emit_fire;

    logic                    wr_vld;
    logic [AW-1:0]           wr_addr;
    logic [SW-1:0]           base;
    logic [SW-1:0]           sum;
    logic [ACC_W-1:0]        wr_val;

    // Next-state and handshake outputs; everything is forced quiet while rst is high.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        issue     = 1'b0;
        emit_fire = 1'b0;
        in_ready  = 1'b0;
        pim_en    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            busy = (state_q != IDLE);
            case (state_q)
                IDLE, WAIT_TILE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = SWEEP;
                    end
                end
                SWEEP: begin
                    pim_en = 1'b1;
                    issue  = 1'b1;
                    if (col_q == LAST_COL) state_d = DRAIN;
                end
                DRAIN: begin
                    if (drain_q == LAST_DRAIN)
                        state_d = (tile_q == LAST_TILE) ? EMIT : WAIT_TILE;
                end
                EMIT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        emit_fire = 1'b1;
                        if (emit_q == LAST_COL) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            emit_q  <= '0;
            tile_q  <= '0;
            drain_q <= '0;
            feat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= emit_fire && (emit_q == LAST_COL);
            if (accept) feat_q <= in_feature;
            if (issue) col_q <= (col_q == LAST_COL) ? '0 : col_q + 1'b1;
            if (emit_fire) emit_q <= (emit_q == LAST_COL) ? '0 : emit_q + 1'b1;
            if (state_q == IDLE) tile_q <= '0;
            if (state_q == DRAIN) begin
                drain_q <= (drain_q == LAST_DRAIN) ? '0 : drain_q + 1'b1;
                if (drain_q == LAST_DRAIN && tile_q != LAST_TILE) tile_q <= tile_q + 1'b1;
            end
        end
    end

    // In-flight read tracker: entry LAT-1 lines up with the ADC result of that read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pv_q[i] <= 1'b0;
                pa_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= issue;
            pa_q[0] <= col_q;
            for (int i = 1; i < LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
        end
    end

    assign wr_vld  = pv_q[LAT-1];
    assign wr_addr = pa_q[LAT-1];

    // Tile 0 overwrites, so stale sums from an aborted vector never leak forward.
    always_comb begin
        base   = (tile_q == '0) ? '0 : SW'(acc[wr_addr]);
        sum    = base + SW'(pim_out);
        wr_val = (sum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_vld) acc[wr_addr] <= wr_val;
    end

    assign pim_feature = rst ? '0 : feat_q;
    assign pim_addr    = pim_en ? col_q : '0;
    assign out_data    = out_valid ? acc[emit_q] : '0;
    assign out_addr    = out_valid ? emit_q : '0;
    assign out_last    = out_valid && (emit_q == LAST_COL);
    assign done        = !rst && done_q;

endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched with a crossbar model driven from a per-vector value table.
module tb_conv_sched;

    localparam int INPUT_SIZE = 128;
    localparam int DEPTH      = 32;
    localparam int ADC_P      = 8;
    localparam int TILES      = 4;
    localparam int LAT        = 1;
    localparam int AW         = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic [INPUT_SIZE-1:0] in_feature = '0;
    logic [ADC_P-1:0]      pim_out = '0;
    logic                  out_ready = 1'b0;

    logic                  in_ready, pim_en, out_valid, out_last, busy, done;
    logic [INPUT_SIZE-1:0] pim_feature;
    logic [AW-1:0]         pim_addr, out_addr;
    logic [9:0]            out_data;

    logic                  in_ready9, pim_en9, out_valid9, out_last9, busy9, done9;
    logic [INPUT_SIZE-1:0] pim_feature9;
    logic [AW-1:0]         pim_addr9, out_addr9;
    logic [8:0]            out_data9;

    conv_sched #(.INPUT_SIZE(INPUT_SIZE), .DEPTH(DEPTH), .ADC_P(ADC_P), .TILES(TILES),
                 .LAT(LAT), .ACC_W(10), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_feature(in_feature),
        .pim_en(pim_en), .pim_feature(pim_feature), .pim_addr(pim_addr), .pim_out(pim_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .done(done));

    conv_sched #(.INPUT_SIZE(INPUT_SIZE), .DEPTH(DEPTH), .ADC_P(ADC_P), .TILES(TILES),
                 .LAT(LAT), .ACC_W(9), .AW(AW)) dut9 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9), .in_feature(in_feature),
        .pim_en(pim_en9), .pim_feature(pim_feature9), .pim_addr(pim_addr9), .pim_out(pim_out),
        .out_valid(out_valid9), .out_ready(out_ready), .out_data(out_data9), .out_addr(out_addr9),
        .out_last(out_last9), .busy(busy9), .done(done9));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: ADC value per (tile, column) and the resulting saturated column sums.
    int tbl [TILES][DEPTH];
    int exp10 [DEPTH];
    int exp9  [DEPTH];

    function automatic void set_table(input int mode);
        for (int a = 0; a < DEPTH; a++) begin
            int s = 0;
            for (int t = 0; t < TILES; t++) begin
                case (mode)
                    0:       tbl[t][a] = 255;
                    1:       tbl[t][a] = a + t;
                    2:       tbl[t][a] = 1;
                    default: tbl[t][a] = int'($urandom_range(0, 255));
                endcase
                s += tbl[t][a];
            end
            exp10[a] = (s > 1023) ? 1023 : s;
            exp9[a]  = (s > 511) ? 511 : s;
        end
    endfunction

    // Observation state
    int                    start = -1;
    int                    acc_cyc = -1;
    int                    sweep_tile = 0;
    int                    slices_in = 0;
    int                    emit_i = 0;
    int                    done_cnt = 0;
    int                    hs_cnt = 0;
    bit                    pend_done = 0;
    bit                    prev_stall = 0;
    bit                    exp_en;
    logic [AW-1:0]         prev_addr;
    logic [9:0]            prev_data;
    logic [INPUT_SIZE-1:0] feat_exp = '0;
    int                    bp_mode = 0;

    // Crossbar/ADC: result of a read appears LAT=1 cycle after pim_en.
    bit            c_en;
    logic [AW-1:0] c_addr;
    int            c_tile;
    always begin
        @(negedge clk);
        c_en   = pim_en;
        c_addr = pim_addr;
        c_tile = sweep_tile;
        @(posedge clk);
        #1;
        pim_out = c_en ? ADC_P'(tbl[c_tile][c_addr]) : ADC_P'($urandom);
    end

    always begin
        @(posedge clk);
        #1;
        out_ready = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_quiet", {in_ready, pim_en, (pim_feature != '0), pim_addr, out_valid, out_data,
                                out_addr, out_last, busy, done, in_ready9, out_valid9}, '0);
            start = -1; acc_cyc = -1; slices_in = 0; emit_i = 0;
            pend_done = 0; prev_stall = 0;
        end else begin
            exp_en = (start >= 0) && (cyc >= start) && (cyc < start + DEPTH);
            check("pim_en", pim_en, exp_en);
            check("pim_addr", pim_addr, exp_en ? cyc - start : 0);
            if (exp_en) check("pim_feature", pim_feature, feat_exp);
            if (acc_cyc >= 0 && cyc == acc_cyc + DEPTH + LAT)
                check("quiet_before_ready", {in_ready, out_valid}, 0);
            if (acc_cyc >= 0 && cyc == acc_cyc + DEPTH + LAT + 1)
                check("ready_or_emit", in_ready | out_valid, 1);
            check("done", done, pend_done);
            if (pend_done) begin
                check("idle_after_done", {in_ready, busy}, 2'b10);
                done_cnt++;
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_addr", out_addr, prev_addr);
                check("stall_data", out_data, prev_data);
            end
            pend_done = 0;
            if (out_valid && out_ready) begin
                check("out_addr", out_addr, emit_i);
                check("out_data", out_data, exp10[emit_i]);
                check("out_data_w9", out_data9, exp9[emit_i]);
                check("out_last", out_last, emit_i == DEPTH - 1);
                hs_cnt++;
                if (emit_i == DEPTH - 1) begin
                    pend_done = 1;
                    emit_i = 0;
                end else begin
                    emit_i++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = out_addr;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                acc_cyc    = cyc;
                start      = cyc + 1;
                feat_exp   = in_feature;
                sweep_tile = slices_in;
                slices_in  = (slices_in == TILES - 1) ? 0 : slices_in + 1;
            end
        end
    end

    task automatic send_slice(input int gap);
        int n = 0;
        if (gap > 0) begin
            while (!in_ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                check("in_ready_gap", in_ready, 1);
            end
            @(posedge clk);
            #1;
        end
        in_valid   = 1'b1;
        in_feature = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("slice_accepted", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_feature = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_vector(input int mode, input int gap, input int bp);
        int n = 0;
        set_table(mode);
        bp_mode  = bp;
        done_cnt = 0;
        hs_cnt   = 0;
        for (int t = 0; t < TILES; t++) send_slice(gap);
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("handshakes", hs_cnt, DEPTH);
        bp_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_sweep();
        int n = 0;
        set_table(3);
        for (int t = 0; t < 3; t++) send_slice(0);
        @(negedge clk);
        while (!(pim_en && pim_addr == 9) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_addr9", {pim_en, pim_addr}, {1'b1, 5'd9});
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rerst_ready", in_ready, 1);
        check("rerst_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_quiet", {pim_en, out_valid, done, out_last, (pim_feature != '0)}, 0);
        @(posedge clk);
        #1;
        run_vector(0, 0, 0);
        run_vector(1, 0, 0);
        run_vector(3, 0, 1);
        run_vector(0, 7, 0);
        run_vector(3, 7, 1);
        reset_mid_sweep();
        run_vector(2, 0, 1);
        run_vector(3, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
